// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//   Shared defaults and helpers for the sync_fifo block.
//
//   Contents:
//     DEFAULT_DATA_WIDTH  default width of the FIFO data path
//     DEFAULT_DEPTH       default number of storage entries
//     next_ptr()          pointer increment with wrap at depth-1 -> 0, so the
//                         FIFO works for any depth, not only powers of two
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 3;

  // Advance a circular pointer. The wrap is explicit because, for a depth that
  // is not a power of two, the natural binary overflow of the pointer would
  // land on unused addresses.
  function automatic int unsigned next_ptr(input int unsigned ptr,
                                           input int unsigned depth);
    if (ptr >= depth - 1) begin
      return 0;
    end
    return ptr + 1;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
//   DEPTH x DATA_WIDTH register array used as FIFO storage.
//   Contents are never cleared; only the pointers of the enclosing FIFO decide
//   which entries are meaningful.
//
//   Ports:
//     clk    in   1            write clock
//     we     in   1            write enable
//     waddr  in   ADDR_WIDTH   write address (0 .. DEPTH-1)
//     wdata  in   DATA_WIDTH   write data
//     raddr  in   ADDR_WIDTH   read address (0 .. DEPTH-1)
//     rdata  out  DATA_WIDTH   read data, combinational from raddr
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      entry_we;

  // One-hot write-enable decode, one bit per storage entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
    assign entry_we[gi] = we && (waddr == ADDR_WIDTH'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        mem_q[i] <= wdata;
      end
    end
  end

  // Asynchronous read; the FIFO top registers the selected word.
  assign rdata = mem_q[raddr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO between a producer and a consumer in the same domain.
//   Requests that would overflow or underflow are silently dropped. Read data
//   is registered and appears on the same edge that accepts the read.
//   Occupancy is tracked with an explicit counter so any DEPTH >= 2 works.
//
//   Optional feature (compile-time macro SYNC_FIFO_ERR_FLAGS_EN):
//     adds sticky overflow / underflow outputs, cleared only by rst.
//
//   Ports:
//     clk        in   1           clock, all state updates on posedge
//     rst        in   1           synchronous active-high reset
//     wr_en      in   1           write request
//     rd_en      in   1           read request
//     data_in    in   DATA_WIDTH  write data
//     data_out   out  DATA_WIDTH  registered read data, holds when no read
//     full       out  1           count == DEPTH
//     empty      out  1           count == 0
//     overflow   out  1           (SYNC_FIFO_ERR_FLAGS_EN) sticky wr_en & full
//     underflow  out  1           (SYNC_FIFO_ERR_FLAGS_EN) sticky rd_en & empty
// -----------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q,    count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // ---------------------------------------------------------------------------
  // Flag decode from the registered count
  // ---------------------------------------------------------------------------
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Accept decisions use only pre-edge flags: a write while full is dropped
  // even if a read frees a slot on the same edge, and a read while empty is
  // dropped even if a write arrives on the same edge.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;

    if (wr_ok) begin
      wr_ptr_d = ADDR_WIDTH'(next_ptr(32'(wr_ptr_q), DEPTH));
    end

    if (rd_ok) begin
      rd_ptr_d   = ADDR_WIDTH'(next_ptr(32'(rd_ptr_q), DEPTH));
      data_out_d = mem_rdata;
    end

    // Simultaneous accepted read and write leave occupancy unchanged.
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

  // ---------------------------------------------------------------------------
  // Optional sticky error flags
  // ---------------------------------------------------------------------------
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Flags record any illegal request, whether or not the other side is
  // active the same cycle.
  always_comb begin
    overflow_d  = overflow_q  || (wr_en && full);
    underflow_d = underflow_q || (rd_en && empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Self-checking bench for sync_fifo with default parameters. A queue-based
//   reference model tracks FIFO contents, expected read data and (optionally)
//   the sticky error flags. Inputs change on the falling edge; outputs are
//   compared on the next falling edge, after the rising edge has acted.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_data;
  logic          exp_ovf;
  logic          exp_udf;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  // One clock cycle: apply inputs, let the edge act, update model, compare.
  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [DW-1:0] d);
    int  occ;
    logic wr_acc, rd_acc;
    rst     = r;
    wr_en   = w;
    rd_en   = rd;
    data_in = d;
    @(posedge clk);
    occ = model_q.size();
    if (r) begin
      model_q.delete();
      exp_data = '0;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
    end else begin
      wr_acc = w && (occ != DEPTH);
      rd_acc = rd && (occ != 0);
      if (w && occ == DEPTH) exp_ovf = 1'b1;
      if (rd && occ == 0)    exp_udf = 1'b1;
      if (rd_acc) exp_data = model_q.pop_front();
      if (wr_acc) model_q.push_back(d);
    end
    @(negedge clk);
    txn++;
    $display("txn %0d rst=%0d wr=%0d rd=%0d din=%02h dout=%02h full=%0d empty=%0d occ=%0d",
             txn, r, w, rd, d, data_out, full, empty, model_q.size());
    check("data_out", 32'(data_out), 32'(exp_data));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
    check("full", 32'(full), 32'(model_q.size() == DEPTH));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_udf));
`endif
  endtask

  initial begin
    exp_data = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;

    // 1: reset
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_dout", 32'(data_out), 32'h00);

    // 2: fill
    step(1'b0, 1'b1, 1'b0, 8'hA1);
    check("fill1_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'hB2);
    step(1'b0, 1'b1, 1'b0, 8'hC3);
    check("fill3_full", 32'(full), 32'd1);

    // 3: overflow attempt, then write+read while full (no pass-through)
    step(1'b0, 1'b1, 1'b0, 8'hD4);
    check("ovf_full", 32'(full), 32'd1);
    step(1'b0, 1'b1, 1'b1, 8'hE5);
    check("full_wr_rd_dout", 32'(data_out), 32'hA1);
    step(1'b0, 1'b1, 1'b0, 8'hA1);   // refill the slot

    // 4: drain
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("drain1", 32'(data_out), 32'hB2);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("drain2", 32'(data_out), 32'hC3);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("drain3", 32'(data_out), 32'hA1);
    check("drain_empty", 32'(empty), 32'd1);

    // 5: underflow, including read+write while empty (no fall-through)
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("udf_hold", 32'(data_out), 32'hA1);
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    check("udf_wr_hold", 32'(data_out), 32'hA1);

    // 6: sustained write+read at occupancy 1 across pointer wraps
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(8'h10 + i));
      check("wrap_count1", 32'(model_q.size()), 32'd1);
    end
    check("wrap_last", 32'(data_out), 32'h16);

    // Reset mid-stream with a write pending
    step(1'b1, 1'b1, 1'b1, 8'h77);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_dout", 32'(data_out), 32'h00);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic r, w, rd;
      r  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 35));
      rd = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 70));
      step(r, w, rd, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sync_fifo
